// File: rtl/apb_regfile_pkg.sv
// rtl/apb_regfile_pkg.sv - shared types and field layout for the APB payload register file
package apb_regfile_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  localparam int ERR_FLAG_BIT  = 0;
  localparam int ERR_CNT_LSB   = 8;
  localparam int ERR_CNT_W     = 8;
  localparam int ERR_ADDR_LSB  = 16;
  localparam int ERR_ADDR_W    = 8;
  localparam int ERR_STATUS_W  = 32;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

  localparam int PAYLOAD_IDX_W = 8;

  typedef struct packed {
    logic                     hit;
    logic                     is_err_status;
    logic                     is_payload;
    logic                     is_data_size;
    logic [PAYLOAD_IDX_W-1:0] payload_idx;
  } decode_t;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] cnt);
    return (cnt == ERR_CNT_MAX) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/apb_regfile_decode.sv
// rtl/apb_regfile_decode.sv - combinational address decode and error classification
module apb_regfile_decode
  import apb_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned NUM_PAYLOAD     = 4,
  parameter int unsigned ERR_STATUS_ADDR = 1,
  parameter int unsigned PAYLOAD_BASE    = 2,
  parameter int unsigned DATA_SIZE_ADDR  = PAYLOAD_BASE + NUM_PAYLOAD
) (
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  output decode_t                 dec,
  output logic                    err
);

  localparam int unsigned PAYLOAD_END = PAYLOAD_BASE + NUM_PAYLOAD;
  localparam longint unsigned ADDR_SPAN = 64'd1 << ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] MAX_BYTES = DATA_WIDTH'(NUM_PAYLOAD * DATA_WIDTH / 8);

  if (ADDR_WIDTH > 32 || ADDR_WIDTH < 1) begin : g_bad_addr_width
    $error("apb_regfile_decode: ADDR_WIDTH must be 1..32");
  end
  if (ERR_STATUS_ADDR >= PAYLOAD_BASE && ERR_STATUS_ADDR < PAYLOAD_END) begin : g_err_overlap
    $error("apb_regfile_decode: ERR_STATUS_ADDR overlaps payload window");
  end
  if (DATA_SIZE_ADDR >= PAYLOAD_BASE && DATA_SIZE_ADDR < PAYLOAD_END) begin : g_size_overlap
    $error("apb_regfile_decode: DATA_SIZE_ADDR overlaps payload window");
  end
  if (DATA_SIZE_ADDR == ERR_STATUS_ADDR) begin : g_size_err_overlap
    $error("apb_regfile_decode: DATA_SIZE_ADDR equals ERR_STATUS_ADDR");
  end
  if (longint'(PAYLOAD_END) > ADDR_SPAN || longint'(DATA_SIZE_ADDR) >= ADDR_SPAN ||
      longint'(ERR_STATUS_ADDR) >= ADDR_SPAN) begin : g_addr_range
    $error("apb_regfile_decode: register map exceeds paddr range");
  end

  logic [31:0] addr32;
  assign addr32 = 32'(paddr);

  always_comb begin
    dec               = '0;
    dec.is_err_status = (addr32 == ERR_STATUS_ADDR);
    dec.is_payload    = (addr32 >= PAYLOAD_BASE) && (addr32 < PAYLOAD_END);
    dec.is_data_size  = (addr32 == DATA_SIZE_ADDR);
    dec.hit           = dec.is_err_status | dec.is_payload | dec.is_data_size;
    if (dec.is_payload) begin
      dec.payload_idx = PAYLOAD_IDX_W'(addr32 - PAYLOAD_BASE);
    end

    err = !dec.hit;
    if (pwrite && dec.is_err_status) begin
      err = 1'b1;
    end
    // A size must be written whole and must fit inside the payload buffer.
    if (pwrite && dec.is_data_size && ((pstrb != '1) || (pwdata > MAX_BYTES))) begin
      err = 1'b1;
    end
  end

endmodule

// File: rtl/apb_payload_regfile.sv
// rtl/apb_payload_regfile.sv - APB4 slave holding payload words, data size/commit and error status
module apb_payload_regfile
  import apb_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned NUM_PAYLOAD     = 4,
  parameter int unsigned WAIT_STATES     = 0,
  parameter int unsigned ERR_STATUS_ADDR = 1,
  parameter int unsigned PAYLOAD_BASE    = 2,
  parameter int unsigned DATA_SIZE_ADDR  = PAYLOAD_BASE + NUM_PAYLOAD
) (
  input  logic                              pclk,
  input  logic                              presetn,
  input  logic                              psel,
  input  logic                              penable,
  input  logic                              pwrite,
  input  logic [ADDR_WIDTH-1:0]             paddr,
  input  logic [DATA_WIDTH-1:0]             pwdata,
  input  logic [DATA_WIDTH/8-1:0]           pstrb,
  output logic [DATA_WIDTH-1:0]             prdata,
  output logic                              pready,
  output logic                              pslverr,
  output logic [NUM_PAYLOAD*DATA_WIDTH-1:0] payload_o,
  output logic [DATA_WIDTH-1:0]             data_size_o,
  output logic                              commit_o
);

  if (DATA_WIDTH == 0 || (DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("apb_payload_regfile: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (NUM_PAYLOAD < 1 || NUM_PAYLOAD > 256) begin : g_bad_num_payload
    $error("apb_payload_regfile: NUM_PAYLOAD must be 1..256");
  end
  if (WAIT_STATES > 15) begin : g_bad_wait_states
    $error("apb_payload_regfile: WAIT_STATES must be 0..15");
  end

  localparam int NBYTES = DATA_WIDTH / 8;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic [DATA_WIDTH-1:0]   payload_q [NUM_PAYLOAD];
  logic [DATA_WIDTH-1:0]   data_size_q;
  logic [ERR_STATUS_W-1:0] err_status_q;
  logic                    commit_q;

  decode_t                 dec;
  logic                    dec_err;
  logic                    complete;
  logic                    wr_ok;
  logic                    rd_ok;
  logic [DATA_WIDTH-1:0]   rd_mux;
  logic [ERR_ADDR_W-1:0]   err_addr;

  apb_regfile_decode #(
    .DATA_WIDTH      (DATA_WIDTH),
    .ADDR_WIDTH      (ADDR_WIDTH),
    .NUM_PAYLOAD     (NUM_PAYLOAD),
    .ERR_STATUS_ADDR (ERR_STATUS_ADDR),
    .PAYLOAD_BASE    (PAYLOAD_BASE),
    .DATA_SIZE_ADDR  (DATA_SIZE_ADDR)
  ) u_decode (
    .paddr  (paddr),
    .pwrite (pwrite),
    .pstrb  (pstrb),
    .pwdata (pwdata),
    .dec    (dec),
    .err    (dec_err)
  );

  assign complete = (state_q == ACCESS) && psel && penable && (cnt_q == 4'd0);
  assign wr_ok    = complete && pwrite && !dec_err;
  assign rd_ok    = complete && !pwrite && !dec_err;
  assign err_addr = ERR_ADDR_W'(32'(paddr));

  always_comb begin
    rd_mux = '0;
    if (dec.is_err_status) begin
      rd_mux = DATA_WIDTH'(err_status_q);
    end else if (dec.is_data_size) begin
      rd_mux = data_size_q;
    end else if (dec.is_payload) begin
      for (int i = 0; i < int'(NUM_PAYLOAD); i++) begin
        if (dec.payload_idx == PAYLOAD_IDX_W'(i)) begin
          rd_mux = payload_q[i];
        end
      end
    end
  end

  assign pready  = complete;
  assign pslverr = complete && dec_err;
  assign prdata  = (complete && dec.hit && !dec_err) ? rd_mux : '0;

  for (genvar g = 0; g < int'(NUM_PAYLOAD); g++) begin : g_payload_out
    assign payload_o[g*DATA_WIDTH +: DATA_WIDTH] = payload_q[g];
  end
  assign data_size_o = data_size_q;
  assign commit_o    = commit_q;

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (psel && !penable) begin
            state_q <= ACCESS;
            cnt_q   <= 4'(WAIT_STATES);
          end
        end
        ACCESS: begin
          if (!psel) begin
            state_q <= IDLE;
          end else if (!penable) begin
            // Fresh setup phase while still in ACCESS restarts the wait count.
            cnt_q <= 4'(WAIT_STATES);
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      for (int i = 0; i < int'(NUM_PAYLOAD); i++) begin
        payload_q[i] <= '0;
      end
      data_size_q  <= '0;
      err_status_q <= '0;
      commit_q     <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      if (wr_ok && dec.is_payload) begin
        for (int i = 0; i < int'(NUM_PAYLOAD); i++) begin
          if (dec.payload_idx == PAYLOAD_IDX_W'(i)) begin
            for (int b = 0; b < NBYTES; b++) begin
              if (pstrb[b]) begin
                payload_q[i][b*8 +: 8] <= pwdata[b*8 +: 8];
              end
            end
          end
        end
      end
      if (wr_ok && dec.is_data_size) begin
        data_size_q <= pwdata;
        commit_q    <= 1'b1;
      end
      if (complete && dec_err) begin
        err_status_q[ERR_FLAG_BIT]                   <= 1'b1;
        err_status_q[ERR_CNT_LSB +: ERR_CNT_W]       <= sat_inc(err_status_q[ERR_CNT_LSB +: ERR_CNT_W]);
        err_status_q[ERR_ADDR_LSB +: ERR_ADDR_W]     <= err_addr;
      end else if (rd_ok && dec.is_err_status) begin
        err_status_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_payload_regfile.sv
// tb/tb_apb_payload_regfile.sv - directed vector bench for apb_payload_regfile
module tb_apb_payload_regfile;

  logic         pclk = 1'b0;
  logic         presetn;
  logic         psel, penable, pwrite;
  logic [7:0]   paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [31:0]  prdata;
  logic         pready, pslverr;
  logic [127:0] payload_o;
  logic [31:0]  data_size_o;
  logic         commit_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 pclk = ~pclk;

  apb_payload_regfile #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (8),
    .NUM_PAYLOAD (4),
    .WAIT_STATES (2)
  ) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pstrb       (pstrb),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .payload_o   (payload_o),
    .data_size_o (data_size_o),
    .commit_o    (commit_o)
  );

  typedef struct {
    string       name;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                          input logic [3:0] st, output logic [31:0] rd, output logic err,
                          output int waits, output logic commit_after);
    logic done;
    done = 1'b0;
    rd = '0;
    err = 1'b0;
    waits = 0;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
    @(posedge pclk); #1;
    penable = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge pclk);
      if (pready) begin
        rd = prdata;
        err = pslverr;
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge pclk); #1;
    end
    commit_after = commit_o;
    psel = 1'b0; penable = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: no pready for addr 0x%02h within 20 cycles", addr);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] rd;
    logic err, cm;
    int w;
    apb_xfer(v.wr, v.addr, v.wdata, v.strb, rd, err, w, cm);
    check({v.name, " pslverr"}, 32'(err), 32'(v.exp_err));
    if (!v.wr) check({v.name, " prdata"}, rd, v.exp_rdata);
  endtask

  logic [31:0] rd;
  logic        err, cm;
  int          w;

  initial begin
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(posedge pclk);
    #1 presetn = 1'b1;

    check("reset pready", 32'(pready), 32'd0);
    check("reset commit", 32'(commit_o), 32'd0);
    check("reset payload_o[31:0]", payload_o[31:0], 32'd0);

    vecs.push_back('{"rst rd p0",   1'b0, 8'h02, 32'h0, 4'h0, 32'h0, 1'b0});
    vecs.push_back('{"rst rd p1",   1'b0, 8'h03, 32'h0, 4'h0, 32'h0, 1'b0});
    vecs.push_back('{"rst rd p2",   1'b0, 8'h04, 32'h0, 4'h0, 32'h0, 1'b0});
    vecs.push_back('{"rst rd p3",   1'b0, 8'h05, 32'h0, 4'h0, 32'h0, 1'b0});
    vecs.push_back('{"rst rd size", 1'b0, 8'h06, 32'h0, 4'h0, 32'h0, 1'b0});
    vecs.push_back('{"rst rd err",  1'b0, 8'h01, 32'h0, 4'h0, 32'h0, 1'b0});
    vecs.push_back('{"wr p0",       1'b1, 8'h02, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{"rd p0",       1'b0, 8'h02, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{"wr p1 zero",  1'b1, 8'h03, 32'h0, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{"wr p1 strb5", 1'b1, 8'h03, 32'hFFFFFFFF, 4'h5, 32'h0, 1'b0});
    vecs.push_back('{"rd p1",       1'b0, 8'h03, 32'h0, 4'h0, 32'h00FF00FF, 1'b0});
    vecs.push_back('{"wr p1 strb0", 1'b1, 8'h03, 32'hAAAAAAAA, 4'h0, 32'h0, 1'b0});
    vecs.push_back('{"rd p1 again", 1'b0, 8'h03, 32'h0, 4'h0, 32'h00FF00FF, 1'b0});
    vecs.push_back('{"wr errstat",  1'b1, 8'h01, 32'h12345678, 4'hF, 32'h0, 1'b1});
    vecs.push_back('{"rd unmapped", 1'b0, 8'h40, 32'h0, 4'h0, 32'h0, 1'b1});
    vecs.push_back('{"rd errstat",  1'b0, 8'h01, 32'h0, 4'h0, 32'h00400201, 1'b0});
    vecs.push_back('{"rd errstat0", 1'b0, 8'h01, 32'h0, 4'h0, 32'h0, 1'b0});
    vecs.push_back('{"wr p0 strb8", 1'b1, 8'h02, 32'h11223344, 4'h8, 32'h0, 1'b0});
    vecs.push_back('{"rd p0 merge", 1'b0, 8'h02, 32'h0, 4'h0, 32'h11ADBEEF, 1'b0});
    vecs.push_back('{"rd p3 zero",  1'b0, 8'h05, 32'h0, 4'h0, 32'h0, 1'b0});
    vecs.push_back('{"rd addr7",    1'b0, 8'h07, 32'h0, 4'h0, 32'h0, 1'b1});
    vecs.push_back('{"rd err a7",   1'b0, 8'h01, 32'h0, 4'h0, 32'h00070101, 1'b0});

    foreach (vecs[i]) run_vec(vecs[i]);

    check("payload_o word1", payload_o[63:32], 32'h00FF00FF);
    check("payload_o word0", payload_o[31:0], 32'h11ADBEEF);

    apb_xfer(1'b1, 8'h02, 32'hCAFEF00D, 4'hF, rd, err, w, cm);
    check("wait states", 32'(w), 32'd2);

    apb_xfer(1'b1, 8'h06, 32'd16, 4'hF, rd, err, w, cm);
    check("size16 pslverr", 32'(err), 32'd0);
    check("size16 commit", 32'(cm), 32'd1);
    check("size16 data_size_o", data_size_o, 32'd16);
    @(posedge pclk); #1;
    check("commit one cycle", 32'(commit_o), 32'd0);
    apb_xfer(1'b1, 8'h06, 32'd17, 4'hF, rd, err, w, cm);
    check("size17 pslverr", 32'(err), 32'd1);
    check("size17 commit", 32'(cm), 32'd0);
    check("size17 data_size_o", data_size_o, 32'd16);
    apb_xfer(1'b1, 8'h06, 32'd4, 4'h7, rd, err, w, cm);
    check("size partial strb pslverr", 32'(err), 32'd1);
    apb_xfer(1'b0, 8'h06, 32'd0, 4'h0, rd, err, w, cm);
    check("size readback", rd, 32'd16);
    apb_xfer(1'b0, 8'h01, 32'd0, 4'h0, rd, err, w, cm);
    check("err after size", rd, 32'h00060201);

    for (int i = 0; i < 300; i++) apb_xfer(1'b1, 8'h01, 32'h0, 4'hF, rd, err, w, cm);
    apb_xfer(1'b0, 8'h01, 32'd0, 4'h0, rd, err, w, cm);
    check("err count saturates", rd, 32'h0001FF01);

    // Master abort: psel drops in the middle of the wait states.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h02; pwdata = 32'h55555555; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    apb_xfer(1'b0, 8'h02, 32'd0, 4'h0, rd, err, w, cm);
    check("abort no write", rd, 32'hCAFEF00D);
    apb_xfer(1'b0, 8'h01, 32'd0, 4'h0, rd, err, w, cm);
    check("abort no error", rd, 32'h0);

    // Access phase without setup must be ignored.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h02; pwdata = 32'h0; pstrb = 4'hF;
    @(negedge pclk);
    check("no setup pready", 32'(pready), 32'd0);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    check("no setup payload", payload_o[31:0], 32'hCAFEF00D);

    // Reset in the middle of a transfer.
    apb_xfer(1'b1, 8'h01, 32'h0, 4'hF, rd, err, w, cm);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h03; pwdata = 32'h77777777; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    presetn = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1; psel = 1'b0; penable = 1'b0;
    check("midreset payload_o", payload_o[63:32] | payload_o[31:0], 32'h0);
    check("midreset data_size", data_size_o, 32'h0);
    apb_xfer(1'b0, 8'h01, 32'd0, 4'h0, rd, err, w, cm);
    check("midreset errstat", rd, 32'h0);
    apb_xfer(1'b0, 8'h03, 32'd0, 4'h0, rd, err, w, cm);
    check("midreset p1", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
